// File: rtl/vlastp_trg_coinc_if.sv
// Signal bundle between the FEE hit/busy lines and the coincidence stage.
// The master drives hits, selects and busy lines; the slave returns the trigger outputs.
interface vlastp_trg_coinc_if;
    logic [7:0]  hit_a_i;
    logic [7:0]  hit_b_i;
    logic [7:0]  red_sel_i;
    logic [7:0]  coin_mask_i;
    logic        ext_trig_en_i;
    logic        ext_trig_i;
    logic        busy_i;
    logic [3:0]  si_busy_i;
    logic        trg_o;
    logic [1:0]  trg_src_o;
    logic [7:0]  trg_pattern_o;
    logic [1:0]  state_o;
    logic [15:0] trg_cnt_o;
    logic [15:0] lost_cnt_o;

    modport master (
        output hit_a_i, hit_b_i, red_sel_i, coin_mask_i,
               ext_trig_en_i, ext_trig_i, busy_i, si_busy_i,
        input  trg_o, trg_src_o, trg_pattern_o, state_o, trg_cnt_o, lost_cnt_o
    );

    modport slave (
        input  hit_a_i, hit_b_i, red_sel_i, coin_mask_i,
               ext_trig_en_i, ext_trig_i, busy_i, si_busy_i,
        output trg_o, trg_src_o, trg_pattern_o, state_o, trg_cnt_o, lost_cnt_o
    );
endinterface

// File: rtl/vlastp_trg_coinc.sv
// Hit conditioning, coincidence windows and trigger/dead-time FSM for vlastp_trigger_top.
// Define VLASTP_TRG_CNT_EN to build the saturating trigger and lost-event counters.
module vlastp_trg_coinc #(
    parameter int WIN_LEN   = 8,
    parameter int TRG_WIDTH = 4,
    parameter int DEAD_LEN  = 200
) (
    input  logic                clk_i,
    input  logic                rst_i,
    vlastp_trg_coinc_if.slave   bus
);
    localparam int WIN_EFF   = (WIN_LEN < 1) ? 1 : WIN_LEN;
    localparam int WW        = $clog2(WIN_EFF + 1);
    localparam int TW_EFF    = (TRG_WIDTH < 1) ? 1 : TRG_WIDTH;
    localparam int DL_EFF    = (DEAD_LEN < 0) ? 0 : DEAD_LEN;
    localparam int PH_MAX    = (TW_EFF > DL_EFF) ? TW_EFF : DL_EFF;
    localparam int PW        = $clog2(PH_MAX + 1);
    localparam int TRG_LAST  = TW_EFF - 1;
    localparam int DEAD_LAST = (DL_EFF > 0) ? DL_EFF - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRIG = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    logic [7:0] r_hit_a_s1, r_hit_a_s2;
    logic [7:0] r_hit_b_s1, r_hit_b_s2;
    logic       r_ext_s1, r_ext_s2;
    logic       r_busy_s1, r_busy_s2;
    logic [3:0] r_si_s1, r_si_s2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hit_a_s1 <= '0;
            r_hit_a_s2 <= '0;
            r_hit_b_s1 <= '0;
            r_hit_b_s2 <= '0;
            r_ext_s1   <= 1'b0;
            r_ext_s2   <= 1'b0;
            r_busy_s1  <= 1'b0;
            r_busy_s2  <= 1'b0;
            r_si_s1    <= '0;
            r_si_s2    <= '0;
        end else begin
            r_hit_a_s1 <= bus.hit_a_i;
            r_hit_a_s2 <= r_hit_a_s1;
            r_hit_b_s1 <= bus.hit_b_i;
            r_hit_b_s2 <= r_hit_b_s1;
            r_ext_s1   <= bus.ext_trig_i;
            r_ext_s2   <= r_ext_s1;
            r_busy_s1  <= bus.busy_i;
            r_busy_s2  <= r_busy_s1;
            r_si_s1    <= bus.si_busy_i;
            r_si_s2    <= r_si_s1;
        end
    end

    // Selected lines get one extra register stage before edge detection so the
    // hit and external paths arrive at the FSM with the same latency.
    logic [7:0] w_sel, r_sel, r_sel_d, w_edge, w_win;
    logic       r_ext_q, r_ext_qd, r_ext_evt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sel     <= '0;
            r_sel_d   <= '0;
            r_ext_q   <= 1'b0;
            r_ext_qd  <= 1'b0;
            r_ext_evt <= 1'b0;
        end else begin
            r_sel     <= w_sel;
            r_sel_d   <= r_sel;
            r_ext_q   <= r_ext_s2;
            r_ext_qd  <= r_ext_q;
            r_ext_evt <= bus.ext_trig_en_i & r_ext_q & ~r_ext_qd;
        end
    end

    assign w_edge = r_sel & ~r_sel_d;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ch
            logic [WW-1:0] r_cnt;

            assign w_sel[gi] = bus.red_sel_i[gi] ? r_hit_b_s2[gi] : r_hit_a_s2[gi];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i)
                    r_cnt <= '0;
                else if (w_edge[gi])
                    r_cnt <= WW'(WIN_EFF);
                else if (r_cnt != '0)
                    r_cnt <= r_cnt - WW'(1);
            end

            assign w_win[gi] = (r_cnt != '0);
        end
    endgenerate

    logic w_coin, r_coin, w_coin_rise, w_req, w_blk;

    assign w_coin      = (bus.coin_mask_i != 8'd0) &&
                         ((w_win & bus.coin_mask_i) == bus.coin_mask_i);
    assign w_coin_rise = w_coin & ~r_coin;
    assign w_req       = w_coin_rise | r_ext_evt;
    assign w_blk       = r_busy_s2 | (|r_si_s2);

    state_t         r_state, w_state_next;
    logic [PW-1:0]  r_ph, w_ph_next;
    logic           w_accept;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_ph    <= '0;
            r_coin  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ph    <= w_ph_next;
            r_coin  <= w_coin;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ph_next    = r_ph;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req && !w_blk) begin
                    w_state_next = ST_TRIG;
                    w_ph_next    = '0;
                    w_accept     = 1'b1;
                end
            end
            ST_TRIG: begin
                if (r_ph == PW'(TRG_LAST)) begin
                    w_ph_next    = '0;
                    w_state_next = (DL_EFF == 0) ? ST_IDLE : ST_DEAD;
                end else begin
                    w_ph_next = r_ph + PW'(1);
                end
            end
            ST_DEAD: begin
                if (r_ph == PW'(DEAD_LAST)) begin
                    w_ph_next    = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_ph_next = r_ph + PW'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_ph_next    = '0;
            end
        endcase
    end

    logic [1:0] r_src;
    logic [7:0] r_pattern;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_src     <= '0;
            r_pattern <= '0;
        end else if (w_accept) begin
            r_src     <= {r_ext_evt, w_coin_rise};
            r_pattern <= w_win;
        end
    end

`ifdef VLASTP_TRG_CNT_EN
    logic [15:0] r_trg_cnt, r_lost_cnt;
    logic        w_lost;

    // A request is lost when vetoed in IDLE or when it arrives during pulse/dead time.
    assign w_lost = w_req & ((r_state != ST_IDLE) | w_blk);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_trg_cnt  <= '0;
            r_lost_cnt <= '0;
        end else begin
            if (w_accept && r_trg_cnt != 16'hFFFF)
                r_trg_cnt <= r_trg_cnt + 16'd1;
            if (w_lost && r_lost_cnt != 16'hFFFF)
                r_lost_cnt <= r_lost_cnt + 16'd1;
        end
    end

    assign bus.trg_cnt_o  = r_trg_cnt;
    assign bus.lost_cnt_o = r_lost_cnt;
`else
    assign bus.trg_cnt_o  = 16'd0;
    assign bus.lost_cnt_o = 16'd0;
`endif

    assign bus.trg_o         = (r_state == ST_TRIG);
    assign bus.state_o       = r_state;
    assign bus.trg_src_o     = r_src;
    assign bus.trg_pattern_o = r_pattern;
endmodule

// File: tb/tb_vlastp_trg_coinc.sv
// Directed bench for vlastp_trg_coinc: coincidence, window edge, vetoes, redundancy,
// external path, counter saturation and asynchronous reset mid-pulse.
module tb_vlastp_trg_coinc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    vlastp_trg_coinc_if bus_if ();

    vlastp_trg_coinc #(
        .WIN_LEN   (8),
        .TRG_WIDTH (4),
        .DEAD_LEN  (200)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int   pulse_cnt  = 0;
    int   run_len    = 0;
    int   last_width = 0;
    logic trg_prev   = 1'b0;

    always @(negedge clk) begin
        if (bus_if.trg_o) begin
            if (!trg_prev)
                pulse_cnt <= pulse_cnt + 1;
            run_len <= run_len + 1;
        end else begin
            if (trg_prev)
                last_width <= run_len;
            run_len <= 0;
        end
        trg_prev <= bus_if.trg_o;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Counter expectations collapse to 0 when the counters are compiled out.
    function automatic logic [31:0] cexp(input logic [31:0] v);
`ifdef VLASTP_TRG_CNT_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_a(input int ch);
        bus_if.hit_a_i[ch] = 1'b1;
        tick(1);
        bus_if.hit_a_i[ch] = 1'b0;
    endtask

    task automatic coinc(input int ch1, input int ch2, input int d);
        pulse_a(ch1);
        tick(d - 1);
        pulse_a(ch2);
    endtask

    task automatic wait_trg(input string tag);
        int n;
        n = 0;
        while (!bus_if.trg_o && n < 40) begin
            tick(1);
            n++;
        end
        check_val(tag, {31'd0, bus_if.trg_o}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus_if.state_o != 2'd0 && n < 600) begin
            tick(1);
            n++;
        end
        check_val(tag, {30'd0, bus_if.state_o}, 32'd0);
    endtask

    int lat;
    int lat_state;
    logic [31:0] exp_lost;

    initial begin
        bus_if.hit_a_i       = '0;
        bus_if.hit_b_i       = '0;
        bus_if.red_sel_i     = '0;
        bus_if.coin_mask_i   = '0;
        bus_if.ext_trig_en_i = 1'b0;
        bus_if.ext_trig_i    = 1'b0;
        bus_if.busy_i        = 1'b0;
        bus_if.si_busy_i     = '0;
        exp_lost             = 32'd0;

        tick(3);
        check_val("rst_trg",     {31'd0, bus_if.trg_o}, 32'd0);
        check_val("rst_state",   {30'd0, bus_if.state_o}, 32'd0);
        check_val("rst_pattern", {24'd0, bus_if.trg_pattern_o}, 32'd0);
        check_val("rst_cnt",     {bus_if.trg_cnt_o, bus_if.lost_cnt_o}, 32'd0);
        rst = 1'b0;
        bus_if.coin_mask_i = 8'h0C;
        tick(3);

        // Basic coincidence, hits 3 apart; trg_o seen on the 5th negedge after the completing hit is sampled.
        pulse_a(2);
        tick(2);
        bus_if.hit_a_i[3] = 1'b1;
        lat = 0;
        lat_state = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (i == 1)
                bus_if.hit_a_i[3] = 1'b0;
            if (bus_if.trg_o && lat == 0) begin
                lat = i;
                lat_state = int'(bus_if.state_o);
            end
        end
        check_val("basic_latency", lat, 32'd5);
        check_val("basic_state_trig", lat_state, 32'd1);
        wait_idle("basic_idle");
        check_val("basic_width",   last_width, 32'd4);
        check_val("basic_pattern", {24'd0, bus_if.trg_pattern_o}, 32'h0C);
        check_val("basic_src",     {30'd0, bus_if.trg_src_o}, 32'd1);
        check_val("basic_trg_cnt", {16'd0, bus_if.trg_cnt_o}, cexp(1));

        // Window edge: exactly 8 apart misses, 7 apart coincides.
        tick(5);
        coinc(2, 3, 8);
        tick(20);
        check_val("win8_pulses",  pulse_cnt, 32'd1);
        check_val("win8_trg_cnt", {16'd0, bus_if.trg_cnt_o}, cexp(1));
        check_val("win8_lost",    {16'd0, bus_if.lost_cnt_o}, cexp(0));
        coinc(2, 3, 7);
        wait_trg("win7_trg");
        wait_idle("win7_idle");
        check_val("win7_pulses",  pulse_cnt, 32'd2);
        check_val("win7_trg_cnt", {16'd0, bus_if.trg_cnt_o}, cexp(2));

        // Si busy veto.
        tick(20);
        bus_if.si_busy_i = 4'b0010;
        tick(4);
        coinc(2, 3, 3);
        tick(20);
        bus_if.si_busy_i = 4'b0000;
        check_val("veto_pulses", pulse_cnt, 32'd2);
        check_val("veto_lost",   {16'd0, bus_if.lost_cnt_o}, cexp(1));
        check_val("veto_state",  {30'd0, bus_if.state_o}, 32'd0);

        // Second coincidence inside dead time is lost.
        tick(5);
        coinc(2, 3, 3);
        wait_trg("dead_first_trg");
        tick(40);
        coinc(2, 3, 3);
        tick(10);
        check_val("dead_state",  {30'd0, bus_if.state_o}, 32'd2);
        check_val("dead_lost",   {16'd0, bus_if.lost_cnt_o}, cexp(2));
        check_val("dead_pulses", pulse_cnt, 32'd3);
        wait_idle("dead_idle");

        // Redundancy: B line selected on channel 2.
        tick(20);
        bus_if.coin_mask_i = 8'h04;
        bus_if.red_sel_i   = 8'h04;
        tick(5);
        bus_if.hit_b_i[2] = 1'b1;
        tick(1);
        bus_if.hit_b_i[2] = 1'b0;
        wait_trg("red_b_trg");
        wait_idle("red_b_idle");
        check_val("red_b_pattern", {24'd0, bus_if.trg_pattern_o}, 32'h04);
        check_val("red_b_pulses",  pulse_cnt, 32'd4);
        tick(20);
        pulse_a(2);
        tick(20);
        check_val("red_a_ignored", pulse_cnt, 32'd4);
        bus_if.red_sel_i   = 8'h00;
        bus_if.coin_mask_i = 8'h0C;
        tick(20);

        // External edge coincident with logic coincidence.
        bus_if.ext_trig_en_i = 1'b1;
        pulse_a(2);
        tick(2);
        bus_if.hit_a_i[3]  = 1'b1;
        bus_if.ext_trig_i  = 1'b1;
        tick(1);
        bus_if.hit_a_i[3]  = 1'b0;
        bus_if.ext_trig_i  = 1'b0;
        wait_trg("both_trg");
        wait_idle("both_idle");
        check_val("both_src",     {30'd0, bus_if.trg_src_o}, 32'd3);
        check_val("both_pulses",  pulse_cnt, 32'd5);
        check_val("both_trg_cnt", {16'd0, bus_if.trg_cnt_o}, cexp(5));
        check_val("both_lost",    {16'd0, bus_if.lost_cnt_o}, cexp(2));

        // External trigger alone.
        tick(20);
        bus_if.ext_trig_i = 1'b1;
        tick(1);
        bus_if.ext_trig_i = 1'b0;
        wait_trg("ext_trg");
        wait_idle("ext_idle");
        check_val("ext_src",     {30'd0, bus_if.trg_src_o}, 32'd2);
        check_val("ext_pattern", {24'd0, bus_if.trg_pattern_o}, 32'h00);
        bus_if.ext_trig_en_i = 1'b0;

        // Lost counter saturation.
        tick(20);
`ifdef VLASTP_TRG_CNT_EN
        force dut.r_lost_cnt = 16'hFFFF;
        tick(1);
        release dut.r_lost_cnt;
        exp_lost = 32'hFFFF;
`else
        exp_lost = 32'd2;
`endif
        bus_if.busy_i = 1'b1;
        tick(4);
        coinc(2, 3, 3);
        tick(20);
        bus_if.busy_i = 1'b0;
        check_val("sat_lost",   {16'd0, bus_if.lost_cnt_o}, cexp(exp_lost));
        check_val("sat_pulses", pulse_cnt, 32'd6);

        // Asynchronous reset in the middle of a pulse.
        tick(20);
        coinc(2, 3, 3);
        wait_trg("rst_mid_trg");
        rst = 1'b1;
        #1;
        check_val("rst_mid_trg_drop", {31'd0, bus_if.trg_o}, 32'd0);
        check_val("rst_mid_state",    {30'd0, bus_if.state_o}, 32'd0);
        check_val("rst_mid_src_pat",  {22'd0, bus_if.trg_src_o, bus_if.trg_pattern_o}, 32'd0);
        check_val("rst_mid_cnt",      {bus_if.trg_cnt_o, bus_if.lost_cnt_o}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
